// File: rtl/mult_div_unit.sv
// 32-bit iterative multiply/divide unit with HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle; results appear only on completion.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;

    logic [31:0] mb_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_step_s;
    logic [32:0] div_top_s;
    logic [31:0] div_diff_s;
    logic [63:0] div_step_s;
    logic [63:0] step_s;
    logic [63:0] prod_s;
    logic        neg_q_s, neg_r_s;
    logic [31:0] res_hi_s, res_lo_s;

    // Magnitude of a 32-bit operand; 0x80000000 maps to itself as an unsigned value.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        logic [31:0] m;
        if (sgn && v[31]) begin
            m = 32'd0 - v;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Datapath: one iteration step on unsigned magnitudes, then sign fix-up of the final step.
    always_comb begin
        mb_s       = mag(b_q, op_q[0]);
        mul_sum_s  = {1'b0, acc_q[63:32]} + {1'b0, mb_s};
        if (acc_q[0]) begin
            mul_step_s = {mul_sum_s, acc_q[31:1]};
        end else begin
            mul_step_s = {1'b0, acc_q[63:1]};
        end
        div_top_s  = acc_q[63:31];
        div_diff_s = div_top_s[31:0] - mb_s;
        if (div_top_s >= {1'b0, mb_s}) begin
            div_step_s = {div_diff_s, acc_q[30:0], 1'b1};
        end else begin
            div_step_s = {acc_q[62:0], 1'b0};
        end
        step_s  = op_q[1] ? div_step_s : mul_step_s;
        neg_q_s = op_q[0] & (a_q[31] ^ b_q[31]);
        neg_r_s = op_q[0] & a_q[31];
        prod_s  = neg_q_s ? (64'd0 - step_s) : step_s;
        if (!op_q[1]) begin
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end else if (b_q == 32'd0) begin
            res_hi_s = a_q;
            res_lo_s = 32'hFFFF_FFFF;
        end else begin
            res_lo_s = neg_q_s ? (32'd0 - step_s[31:0])  : step_s[31:0];
            res_hi_s = neg_r_s ? (32'd0 - step_s[63:32]) : step_s[63:32];
        end
    end

    // Next-state logic: start has priority over MTHI/MTLO; only IDLE accepts either.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = 5'd0;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = {32'd0, mag(a, op[0])};
                end else begin
                    hi_d = hi_we ? wdata : hi_q;
                    lo_d = lo_we ? wdata : lo_q;
                end
            end
            RUN: begin
                acc_d = step_s;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    hi_d    = res_hi_s;
                    lo_d    = res_lo_s;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // State and architectural registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: cycle-level behavioural model, per-cycle compare, directed and random stimulus.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic [31:0] hi, lo;
    logic        busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Architectural result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            2'b00: p = {32'd0, x} * {32'd0, y};
            2'b01: p = sx * sy;
            2'b10: p = (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 32'd0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: accepted op completes 32 edges later; writes only land when idle and not starting.
    bit          m_busy, m_done;
    int          m_left;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
            m_hi <= 32'd0; m_lo <= 32'd0; m_res <= 64'd0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                end
            end else if (start) begin
                m_busy <= 1'b1;
                m_left <= 32;
                m_res  <= ref_calc(op, a, b);
            end else begin
                if (hi_we) m_hi <= wdata;
                if (lo_we) m_lo <= wdata;
            end
        end
    end

    // Compare process: every falling edge outside reset.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("hi", {32'd0, hi}, {32'd0, m_hi});
            chk("lo", {32'd0, lo}, {32'd0, m_lo});
            chk("busy", {63'd0, busy}, {63'd0, m_busy});
            chk("done", {63'd0, done}, {63'd0, m_done});
            chk("done_busy_excl", {63'd0, done & busy}, 64'd0);
        end
    end

    task automatic wait_done(input string name);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (!busy) break;
        end
        chk({name, "_timeout"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done("op");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        chk("pin_div_ovf", ref_calc(2'b11, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        chk("pin_divu100_7", ref_calc(2'b10, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
        repeat (2) @(posedge clk);
        #2;
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(2'b10, 32'd100, 32'd0);
        chk("divu_zero", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(2'b11, 32'hFFFF_FFF0, 32'd0);
        chk("div_zero_neg", {hi, lo}, 64'hFFFF_FFF0_FFFF_FFFF);

        // Start and MTHI during RUN are ignored.
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2; hi_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #2;
        start = 1'b0; hi_we = 1'b0;
        wait_done("divu_busy");
        chk("divu_ignore", {hi, lo}, 64'h0000_0002_0000_000E);

        // Asynchronous reset in the middle of a run, then start on the first edge after release.
        start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFF; b = 32'h0001_2345;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrun_reset_hilo", {hi, lo}, 64'd0);
        chk("midrun_reset_busy", {62'd0, busy, done}, 64'd0);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
        #1;
        reset = 1'b0;
        @(posedge clk); #2;
        start = 1'b0;
        chk("post_reset_accept", {63'd0, busy}, 64'd1);
        wait_done("post_reset");
        chk("multu_3x5", {hi, lo}, 64'h0000_0000_0000_000F);

        // MTHI in IDLE, then start with lo_we on the same edge.
        hi_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk); #2;
        hi_we = 1'b0;
        chk("mthi", {hi, lo}, 64'hCAFE_F00D_0000_000F);
        start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #2;
        start = 1'b0; lo_we = 1'b0;
        chk("start_wins_busy", {63'd0, busy}, 64'd1);
        chk("start_wins_lo", {32'd0, lo}, 64'h0000_000F);
        wait_done("start_wins");
        chk("multu_6x7", {hi, lo}, 64'h0000_0000_0000_002A);

        // Random traffic; start and writes may arrive at any time, including during RUN.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            op    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            hi_we = ($urandom_range(0, 3) == 0);
            lo_we = ($urandom_range(0, 3) == 0);
            wdata = $urandom;
            @(posedge clk); #2;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        wait_done("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none. The datapath width is fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin the operation selected by op; sampled on a rising clk edge.
REQ-005 op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  input  32  multiplicand or dividend (rs).
REQ-007 b  input  32  multiplier or divisor (rt).
REQ-008 hi_we  input  1  MTHI write enable.
REQ-009 lo_we  input  1  MTLO write enable.
REQ-010 wdata  input  32  data written by MTHI/MTLO.
REQ-011 hi  output  32  HI register; feeds the writeback select mux for MFHI.
REQ-012 lo  output  32  LO register; feeds the writeback select mux for MFLO.
REQ-013 busy  output  1  an operation is in progress; the pipeline stalls MFHI/MFLO while busy=1.
REQ-014 done  output  1  one-cycle pulse at completion.

Function
REQ-015 The block SHALL implement a two-state FSM, IDLE and RUN, with a 5-bit iteration counter.
REQ-016 IDLE -> RUN on a clk edge where start=1; the block SHALL latch op, a and b at that edge, and busy SHALL be 1 from that edge.
REQ-017 RUN: the block SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, 32 steps in total.
REQ-018 RUN -> IDLE on the 32nd edge after the start edge; at that edge hi and lo SHALL update, busy SHALL drop to 0, and done SHALL be 1 for exactly one cycle.
REQ-019 Latency SHALL be exactly 32 cycles for every op, including divide-by-zero.
REQ-020 hi and lo SHALL hold their previous values for the whole of RUN; the internal accumulator SHALL NOT be visible on the outputs.
REQ-021 Multiply results: hi = product[63:32], lo = product[31:0]; MULTU treats a and b as unsigned; MULT treats them as two's complement and produces the correct signed 64-bit product.
REQ-022 Divide results: lo = quotient, hi = remainder.
REQ-023 DIV SHALL divide magnitudes, then negate the quotient if the operand signs differ and give the remainder the sign of the dividend (truncating division).
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0x00000000.
REQ-025 Divide by zero (DIVU or DIV): lo = 0xFFFFFFFF, hi = a as latched; no exception is raised.
REQ-026 start while busy=1 SHALL be ignored; the current operation continues unaffected.
REQ-027 hi_we / lo_we in IDLE: the register SHALL load wdata at the edge.
REQ-028 hi_we / lo_we while busy=1 SHALL be ignored.
REQ-029 start together with hi_we or lo_we in IDLE: start wins and the write is ignored.
REQ-030 On the completion edge, a new start SHALL NOT be accepted; the earliest accepted start is the following edge.
REQ-031 done and busy SHALL never both be 1 in the same cycle.

Reset
REQ-032 Asserting reset SHALL immediately force, independent of clk: state IDLE, counter 0, hi = 0, lo = 0, busy = 0, done = 0.
REQ-033 Reset during RUN SHALL abort the operation; no partial result SHALL ever appear on hi or lo.
REQ-034 The first clk edge after reset deasserts SHALL accept start normally.

Verification
REQ-035 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
REQ-036 MULT a=0xFFFFFFFD (-3), b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-037 DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-038 DIVU 100/7 started, then start (MULTU 2*2) and hi_we (wdata=0x1234) applied at cycle 5 of RUN -> both ignored; final lo=0x0000000E, hi=0x00000002.
REQ-039 reset asserted mid-clock at cycle 10 of RUN -> hi=lo=0 and busy=0 immediately; after release, MULTU 3*5 -> lo=0x0000000F, hi=0x00000000.
REQ-040 In IDLE: hi_we=1, wdata=0xCAFEF00D -> hi=0xCAFEF00D next edge, lo unchanged; start and lo_we on the same edge -> operation runs and lo_we is discarded.
